// File: rtl/switch_poll_pkg.sv
// Shared types, widths and helpers for the switch polling controller.
package switch_poll_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, EVAL = 2'd3} state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_EVAL = EVAL;

  localparam int SW_ADDR_W  = 2;
  localparam int AVM_DATA_W = 32;

  // Bits needed to hold 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/switch_debounce_filter.sv
// Debounce filter: tracks a candidate image and commits it after STABLE_COUNT matching samples.
module switch_debounce_filter
  import switch_poll_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int STABLE_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_strobe,
  output logic [DATA_W-1:0] sw_stable,
  output logic              commit,
  output logic [DATA_W-1:0] commit_mask
);

  localparam int CNT_W = clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [DATA_W-1:0] candidate_q, candidate_d;
  logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  new_cnt;

  always_comb begin
    candidate_d  = candidate_q;
    stable_cnt_d = stable_cnt_q;
    stable_d     = stable_q;
    commit       = 1'b0;
    commit_mask  = sample ^ stable_q;
    // Count saturates so a long-stable input does not wrap back below threshold.
    if (sample == candidate_q)
      new_cnt = (stable_cnt_q == CNT_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
    else
      new_cnt = CNT_W'(1);
    if (sample_strobe) begin
      candidate_d  = sample;
      stable_cnt_d = new_cnt;
      if (new_cnt == CNT_MAX && sample != stable_q) begin
        commit   = 1'b1;
        stable_d = sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      candidate_q  <= '0;
      stable_cnt_q <= '0;
      stable_q     <= '0;
    end else begin
      candidate_q  <= candidate_d;
      stable_cnt_q <= stable_cnt_d;
      stable_q     <= stable_d;
    end
  end

  assign sw_stable = stable_q;

endmodule

// File: rtl/switch_poll_ctrl.sv
// Avalon-MM poller for the switch PIO: timed reads, debounce, and a valid/ready change-event stream.
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 16,
  parameter int SW_ADDR      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [SW_ADDR_W-1:0]  avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_W-1:0]     sw_stable,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DATA_W-1:0]     evt_data,
  output logic [DATA_W-1:0]     evt_changed,
  output logic                  evt_overrun,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  localparam int TMR_W  = clog2(POLL_DIV);
  localparam int WAIT_W = clog2(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              timeout_set;

  logic              evt_valid_q, evt_valid_d;
  logic [DATA_W-1:0] evt_data_q, evt_data_d;
  logic [DATA_W-1:0] evt_changed_q, evt_changed_d;
  logic              evt_overrun_q, evt_overrun_d;
  logic              err_timeout_q, err_timeout_d;

  logic              commit;
  logic [DATA_W-1:0] commit_mask;
  logic              handshake;
  logic              overrun_set;

  always_comb begin
    state_d     = state_q;
    tmr_d       = '0;
    wait_d      = wait_q;
    sample_d    = sample_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (tmr_q == TMR_W'(POLL_DIV - 1)) state_d = ST_REQ;
          else                               tmr_d   = tmr_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        if (avm_readdatavalid) begin
          sample_d = avm_readdata[DATA_W-1:0];
          state_d  = ST_EVAL;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EVAL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  switch_debounce_filter #(
    .DATA_W       (DATA_W),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_filter (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample_q),
    .sample_strobe (state_q == ST_EVAL),
    .sw_stable     (sw_stable),
    .commit        (commit),
    .commit_mask   (commit_mask)
  );

  assign handshake = evt_valid_q & evt_ready;

  // A commit into a pending, unaccepted event merges masks; an accepted one starts fresh.
  always_comb begin
    evt_valid_d   = evt_valid_q;
    evt_data_d    = evt_data_q;
    evt_changed_d = evt_changed_q;
    overrun_set   = 1'b0;
    if (commit) begin
      evt_valid_d = 1'b1;
      evt_data_d  = sample_q;
      if (evt_valid_q && !handshake) begin
        evt_changed_d = evt_changed_q | commit_mask;
        overrun_set   = 1'b1;
      end else begin
        evt_changed_d = commit_mask;
      end
    end else if (handshake) begin
      evt_valid_d   = 1'b0;
      evt_changed_d = '0;
    end
    evt_overrun_d = (evt_overrun_q & ~err_clr) | overrun_set;
    err_timeout_d = (err_timeout_q & ~err_clr) | timeout_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      wait_q        <= '0;
      sample_q      <= '0;
      evt_valid_q   <= 1'b0;
      evt_data_q    <= '0;
      evt_changed_q <= '0;
      evt_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      wait_q        <= wait_d;
      sample_q      <= sample_d;
      evt_valid_q   <= evt_valid_d;
      evt_data_q    <= evt_data_d;
      evt_changed_q <= evt_changed_d;
      evt_overrun_q <= evt_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  generate
    if (DATA_W < AVM_DATA_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^avm_readdata[AVM_DATA_W-1:DATA_W];
    end
  endgenerate

  assign avm_address = SW_ADDR_W'(SW_ADDR);
  assign avm_read    = (state_q == ST_REQ);
  assign evt_valid   = evt_valid_q;
  assign evt_data    = evt_data_q;
  assign evt_changed = evt_changed_q;
  assign evt_overrun = evt_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/switch_poll_ctrl.md
Name: switch_poll_ctrl

Overview:
- Avalon-MM master that periodically reads the 8-bit switch PIO data register (address 0, registered readdata).
- Debounces the samples across consecutive polls and keeps a stable switch image.
- Reports each committed change to one consumer over a valid/ready event stream.
- Sits between the interconnect and the CPU-side logic, so software no longer polls the switches directly.

Parameters:
- DATA_W, 8, switch width; matches the PIO in_port width.
- POLL_DIV, 50000, clk cycles between poll launches; must be ≥ 2.
- STABLE_COUNT, 4, consecutive identical samples required to commit; must be ≥ 1.
- TIMEOUT, 16, max cycles in WAIT before abort; must be ≥ 2.
- SW_ADDR, 0, word address of the PIO data register.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = polling runs; 0 = no new polls launched.
- avm_address  out  2  always SW_ADDR.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  fabric stall.
- avm_readdata  in  32  only bits [DATA_W-1:0] are used.
- avm_readdatavalid  in  1  read data return.
- sw_stable  out  DATA_W  current debounced image.
- evt_valid  out  1  event pending.
- evt_ready  in  1  consumer accepts.
- evt_data  out  DATA_W  stable image at the latest commit.
- evt_changed  out  DATA_W  bits changed since the last accepted event.
- evt_overrun  out  1  sticky: a commit was coalesced into an unaccepted event.
- err_timeout  out  1  sticky: a read timed out.
- err_clr  in  1  clears evt_overrun and err_timeout.

Behaviour:
- Reset state: every output 0; FSM IDLE; poll timer, stable_cnt and candidate all 0. A readdatavalid seen in IDLE or REQ is ignored.
- Poll timer:
  - Counts 0..POLL_DIV-1 while enable=1 and FSM=IDLE.
  - At POLL_DIV-1 it wraps to 0 and FSM goes to REQ.
  - enable=0 holds the timer at 0 but does not abort an in-flight read.
  - First avm_read rises POLL_DIV cycles after reset deasserts, with enable=1 throughout.
- FSM states IDLE, REQ, WAIT, EVAL:
  - REQ: avm_read=1, held until avm_waitrequest=0. That cycle moves to WAIT; avm_read is 0 in WAIT.
  - WAIT: on avm_readdatavalid, sample <= readdata[DATA_W-1:0] and go to EVAL.
  - WAIT timeout: wait counter starts at 0 on entry. If TIMEOUT cycles pass without valid, set err_timeout and go to IDLE. No sample is taken and debounce state is unchanged.
  - EVAL (1 cycle):
    - new_cnt = (sample==candidate) ? min(stable_cnt+1, STABLE_COUNT) : 1; candidate <= sample; stable_cnt <= new_cnt.
    - Commit when new_cnt==STABLE_COUNT and sample!=sw_stable. Commit sets sw_stable <= sample, with mask = sample ^ old sw_stable.
    - Always returns to IDLE.
- Event stream:
  - Commit while evt_valid=0: evt_valid<=1, evt_data<=new image, evt_changed<=mask.
  - Commit while evt_valid=1 and evt_ready=0: evt_data<=new image, evt_changed<=evt_changed|mask, set evt_overrun; evt_valid stays 1. While unaccepted, the payload may update; the consumer samples it on the handshake cycle.
  - Handshake (valid&ready) with no commit: evt_valid<=0 and evt_changed<=0 next cycle.
  - Handshake and commit in the same cycle: evt_valid stays 1, evt_data<=new image, evt_changed<=mask only; no overrun.
  - evt_valid never drops without a handshake.
- err_clr: clears both sticky flags. If a set event occurs in the same cycle, set wins.
- Reset mid-read: FSM goes to IDLE; avm_read is 0 on the next cycle; a late readdatavalid is discarded.

Decomposition:
- Package switch_poll_pkg: state enum {IDLE, REQ, WAIT, EVAL}; localparams SW_ADDR_W=2 and AVM_DATA_W=32; a function clog2 for the timer and counter widths.
- Sub-module switch_debounce_filter: candidate, stable_cnt, sw_stable and commit/mask generation. Inputs: sample, sample_strobe. Top level holds the FSM, poll timer, Avalon master and event/flag registers.

Test Plan:
All scenarios use POLL_DIV=4, STABLE_COUNT=3, TIMEOUT=8 unless noted.
- Reset, enable=1, waitrequest=0, PIO returns 0x00 -> first avm_read at cycle 4 after reset deassert; no event; sw_stable=0x00.
- PIO returns 0xA5 for 3 polls -> commit after the third EVAL; evt_valid=1, evt_data=0xA5, evt_changed=0xA5; with evt_ready=1 the next cycle, evt_valid falls.
- Samples 0x01,0x01,0x00,0x01,0x01,0x01 -> commit only after the final 0x01 with evt_changed=0x01; never commits 0x00.
- evt_ready=0: commit 0x0F, then 0x3F -> evt_data=0x3F, evt_changed=0x3F, evt_overrun=1; err_clr -> overrun=0.
- waitrequest high 5 cycles -> avm_read held 6 cycles, address 0; readdatavalid withheld 8 cycles in WAIT -> err_timeout=1, FSM back to IDLE, sw_stable unchanged.
- reset asserted in WAIT, then readdatavalid with 0xFF next cycle -> data ignored; avm_read=0; sw_stable=0x00, evt_valid=0.
